// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle for bit_serial_adder.
// BIT_SERIAL_ADDER_SUB_EN adds the sub select alongside the operands.
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef BIT_SERIAL_ADDER_SUB_EN
   logic             sub;

   modport master (output start, a, b, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first, start/done handshake.
// Optional macro BIT_SERIAL_ADDER_SUB_EN enables subtraction via bus.sub (two's complement).
module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   bit_serial_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   // Half-adder primitive, returns {carry, sum}
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   logic [1:0]       state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt_r;
   logic             cy_r;
   logic             cout_r;
   logic             busy_r;
   logic             done_r;

   logic [1:0]       ha0_s;
   logic [1:0]       ha1_s;
   logic             fa_sum_s;
   logic             fa_cy_s;
   logic [WIDTH-1:0] sum_shift_s;
   logic [WIDTH-1:0] b_load_s;
   logic             cy_load_s;

   // Full-adder cell built from two half-adder stages and a carry OR
   always_comb begin
      ha0_s    = half_add(sa_r[0], sb_r[0]);
      ha1_s    = half_add(ha0_s[0], cy_r);
      fa_sum_s = ha1_s[0];
      fa_cy_s  = ha0_s[1] | ha1_s[1];
   end

   if (WIDTH == 1) begin : g_w1
      assign sum_shift_s = fa_sum_s;
   end else begin : g_wn
      assign sum_shift_s = {fa_sum_s, sum_r[WIDTH-1:1]};
   end

`ifdef BIT_SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1: invert B and seed the carry
   assign b_load_s  = bus.sub ? ~bus.b : bus.b;
   assign cy_load_s = bus.sub;
`else
   assign b_load_s  = bus.b;
   assign cy_load_s = 1'b0;
`endif

   // Control FSM, operand shifters, carry and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         sa_r    <= '0;
         sb_r    <= '0;
         sum_r   <= '0;
         cnt_r   <= '0;
         cy_r    <= 1'b0;
         cout_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  sa_r    <= bus.a;
                  sb_r    <= b_load_s;
                  cy_r    <= cy_load_s;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= SHIFT;
               end
            end
            SHIFT: begin
               sa_r  <= sa_r >> 1;
               sb_r  <= sb_r >> 1;
               sum_r <= sum_shift_s;
               cy_r  <= fa_cy_s;
               cnt_r <= cnt_r + CW'(1);
               if (cnt_r == CW'(WIDTH - 1)) begin
                  cout_r  <= fa_cy_s;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end
            end
            DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): vector table, corner sequences, random sweep.
// Subtraction vectors run only when BIT_SERIAL_ADDER_SUB_EN is defined.
module tb_bit_serial_adder;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   n_done = 0;
   exp_t sb[$];

   bit_serial_adder_if #(.WIDTH(W)) bus ();

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Scoreboard: every done pulse pops one expected result
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("spurious done", {31'd0, bus.done}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", {24'd0, bus.sum}, {24'd0, e.sum});
            check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) check("idle timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   // One operation; a/b are scrambled right after acceptance to prove they were captured
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input bit chk_lat);
      int  lat;
      int  busy_cnt;
      bit  seen;
      exp_t e;
      wait_idle();
      @(negedge clk);
      bus.a = a;
      bus.b = b;
      bus.start = 1'b1;
      e.sum = es;
      e.cout = ec;
      sb.push_back(e);
      lat = 0;
      busy_cnt = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            bus.start = 1'b0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) check("done timeout", 32'd0, 32'd1);
      else if (chk_lat) begin
         check("latency", lat, 32'd9);
         check("busy cycles", busy_cnt, 32'd9);
      end
   endtask

   initial begin
      vec_t vecs[8];
      int   dq[$];
      int   d0;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [W:0]   rs;

      vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'h5A, 8'h3C, 8'h96, 1'b0};
      vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[6] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
      vecs[7] = '{8'hC3, 8'h7E, 8'h41, 1'b1};

      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
      bus.sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset busy", {31'd0, bus.busy}, 32'd0);
      check("reset done", {31'd0, bus.done}, 32'd0);
      check("reset sum", {24'd0, bus.sum}, 32'd0);
      check("reset cout", {31'd0, bus.cout}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors, latency and busy width checked on each
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout, 1'b1);
         if (i == 1) begin
            repeat (3) @(negedge clk);
            check("hold sum", {24'd0, bus.sum}, 32'h00);
            check("hold cout", {31'd0, bus.cout}, 32'd1);
            check("idle done low", {31'd0, bus.done}, 32'd0);
         end
      end

      // Second start 3 cycles into an operation is dropped
      wait_idle();
      @(negedge clk);
      d0 = n_done;
      bus.a = 8'h12;
      bus.b = 8'h34;
      bus.start = 1'b1;
      sb.push_back('{8'h46, 1'b0});
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) bus.start = 1'b0;
         if (c == 3) begin
            bus.a = 8'hFF;
            bus.b = 8'hFF;
            bus.start = 1'b1;
         end
         if (c == 4) bus.start = 1'b0;
      end
      check("single done", n_done - d0, 32'd1);

      // Reset in the middle of an operation aborts it without a done
      wait_idle();
      @(negedge clk);
      bus.a = 8'hAA;
      bus.b = 8'h55;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort done", {31'd0, bus.done}, 32'd0);
      check("abort sum", {24'd0, bus.sum}, 32'd0);
      check("abort cout", {31'd0, bus.cout}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d0 = n_done;
      repeat (15) @(negedge clk);
      check("no done after abort", n_done - d0, 32'd0);
      run_op(8'h01, 8'h02, 8'h03, 1'b0, 1'b1);

      // start held high: re-accepted every WIDTH+2 cycles
      wait_idle();
      @(negedge clk);
      bus.a = 8'h21;
      bus.b = 8'h43;
      bus.start = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back('{8'h64, 1'b0});
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (c == 21) bus.start = 1'b0;
         if (bus.done) dq.push_back(c);
      end
      check("b2b done count", dq.size(), 32'd3);
      if (dq.size() == 3) begin
         check("b2b first done", dq[0], 32'd9);
         check("b2b gap 1", dq[1] - dq[0], 32'd10);
         check("b2b gap 2", dq[2] - dq[1], 32'd10);
      end

`ifdef BIT_SERIAL_ADDER_SUB_EN
      wait_idle();
      bus.sub = 1'b1;
      run_op(8'h10, 8'h01, 8'h0F, 1'b1, 1'b1);
      run_op(8'h01, 8'h02, 8'hFF, 1'b0, 1'b1);
      wait_idle();
      @(negedge clk);
      bus.sub = 1'b0;
`endif

      // Random sweep against a+b
      for (int i = 0; i < 200; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = {1'b0, ra} + {1'b0, rb};
         run_op(ra, rb, rs[W-1:0], rs[W], 1'b0);
      end

      repeat (12) @(negedge clk);
      check("scoreboard drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
